// File: rtl/s_axil_regfile.sv
// AXI4-Lite slave register file: REG_COUNT RW control registers followed by STATUS_COUNT RO status words.
// AW and W are buffered independently; a write commits on the edge where both halves are present.
module s_axil_regfile #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_COUNT    = 6,
  parameter int STATUS_COUNT = 2,
  localparam int STRB_W      = DATA_WIDTH / 8,
  localparam int ADDR_LSB    = $clog2(STRB_W),
  localparam int IDX_RAW     = $clog2(REG_COUNT + STATUS_COUNT),
  localparam int IDX_W       = (IDX_RAW < 1) ? 1 : IDX_RAW,
  localparam int ST_N        = (STATUS_COUNT > 0) ? STATUS_COUNT : 1
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic [ADDR_WIDTH-1:0]             awaddr_i,
  input  logic                              awvalid_i,
  output logic                              awready_o,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  input  logic [STRB_W-1:0]                 wstrb_i,
  input  logic                              wvalid_i,
  output logic                              wready_o,
  output logic [1:0]                        bresp_o,
  output logic                              bvalid_o,
  input  logic                              bready_i,
  input  logic [ADDR_WIDTH-1:0]             araddr_i,
  input  logic                              arvalid_i,
  output logic                              arready_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic [1:0]                        rresp_o,
  output logic                              rvalid_o,
  input  logic                              rready_i,
  output logic [REG_COUNT*DATA_WIDTH-1:0]   regs_o,
  output logic [REG_COUNT-1:0]              wr_pulse_o,
  input  logic [ST_N*DATA_WIDTH-1:0]        status_i
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {TGT_RW, TGT_RO, TGT_NONE} tgt_e;

  logic                                 aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0]                aw_addr_q;
  logic [DATA_WIDTH-1:0]                w_data_q;
  logic [STRB_W-1:0]                    w_strb_q;
  logic                                 bvalid_q;
  logic [1:0]                           bresp_q;
  logic                                 rvalid_q;
  logic [1:0]                           rresp_q;
  logic [DATA_WIDTH-1:0]                rdata_q;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [REG_COUNT-1:0]                 wr_pulse_q, wr_pulse_d;

  function automatic tgt_e decode(input logic [ADDR_WIDTH-1:0] a);
    logic [IDX_W-1:0] ix;
    ix = a[ADDR_LSB +: IDX_W];
    if ((a >> (ADDR_LSB + IDX_W)) != '0) return TGT_NONE;
    if (int'(ix) < REG_COUNT) return TGT_RW;
    if (int'(ix) < REG_COUNT + STATUS_COUNT) return TGT_RO;
    return TGT_NONE;
  endfunction

  // Write path: a half arriving this cycle counts as present, so the commit
  // lands on the same edge as the later handshake.
  logic                  aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;
  tgt_e                  wr_tgt;

  assign aw_hs   = awvalid_i && !aw_held_q;
  assign w_hs    = wvalid_i && !w_held_q;
  assign wr_addr = aw_held_q ? aw_addr_q : awaddr_i;
  assign wr_data = w_held_q ? w_data_q : wdata_i;
  assign wr_strb = w_held_q ? w_strb_q : wstrb_i;
  assign wr_idx  = wr_addr[ADDR_LSB +: IDX_W];
  assign wr_tgt  = decode(wr_addr);
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (commit && wr_tgt == TGT_RW) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (int'(wr_idx) == i) begin
          wr_pulse_d[i] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read path: status words are sampled in the AR handshake cycle.
  logic                  ar_hs;
  logic [IDX_W-1:0]      rd_idx;
  tgt_e                  rd_tgt;
  logic [DATA_WIDTH-1:0] rd_word;

  assign ar_hs  = arvalid_i && !rvalid_q;
  assign rd_idx = araddr_i[ADDR_LSB +: IDX_W];
  assign rd_tgt = decode(araddr_i);

  always_comb begin
    rd_word = '0;
    if (rd_tgt == TGT_RW) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (int'(rd_idx) == i) rd_word = regs_q[i];
      end
    end else if (rd_tgt == TGT_RO) begin
      for (int s = 0; s < STATUS_COUNT; s++) begin
        if (int'(rd_idx) == REG_COUNT + s) rd_word = status_i[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= awaddr_i;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= wdata_i;
        w_strb_q <= wstrb_i;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        case (wr_tgt)
          TGT_RW:  bresp_q <= RESP_OKAY;
          TGT_RO:  bresp_q <= RESP_SLVERR;
          default: bresp_q <= RESP_DECERR;
        endcase
      end else if (bvalid_q && bready_i) begin
        bvalid_q  <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= (rd_tgt == TGT_NONE) ? RESP_DECERR : RESP_OKAY;
      end else if (rvalid_q && rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign awready_o  = !aw_held_q;
  assign wready_o   = !w_held_q;
  assign arready_o  = !rvalid_q;
  assign bvalid_o   = bvalid_q;
  assign bresp_o    = bresp_q;
  assign rvalid_o   = rvalid_q;
  assign rresp_o    = rresp_q;
  assign rdata_o    = rdata_q;
  assign regs_o     = regs_q;
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_s_axil_regfile.sv
// Bench for s_axil_regfile: directed scenarios plus random traffic against a word-indexed reference model.
module tb_s_axil_regfile;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 6;
  localparam int NS = 2;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              areset;
  logic [AW-1:0]     awaddr_i, araddr_i;
  logic              awvalid_i, awready_o, wvalid_i, wready_o;
  logic [DW-1:0]     wdata_i, rdata_o;
  logic [SW-1:0]     wstrb_i;
  logic [1:0]        bresp_o, rresp_o;
  logic              bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i;
  logic [NR*DW-1:0]  regs_o;
  logic [NR-1:0]     wr_pulse_o;
  logic [NS*DW-1:0]  status_i;

  always #5 clk = ~clk;

  s_axil_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(NR), .STATUS_COUNT(NS)) dut (
    .clk(clk), .areset(areset),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .status_i(status_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_stat [NS];

  always_comb begin
    status_i = '0;
    for (int i = 0; i < NS; i++) status_i[i*DW +: DW] = m_stat[i];
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return int'(a >> 2);
  endfunction

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_regs[i];
    return r;
  endfunction

  // Called and returns at posedge+1. If nxt_en, a second AW is presented while B is held.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                          input int aw_dly, input int w_dly, input int bdly,
                          input bit nxt_en, input logic [AW-1:0] nxt_addr);
    int w;
    int cyc;
    bit aw_done, w_done, aw_f, w_f, b_f;
    logic [1:0] exp_b;
    logic [NR-1:0] exp_p;
    w = word_of(addr);
    exp_p = '0;
    exp_b = (w < NR) ? 2'b00 : (w < NR + NS) ? 2'b10 : 2'b11;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 64) begin
      if (!aw_done) begin awvalid_i = (cyc >= aw_dly); awaddr_i = addr; end
      if (!w_done) begin wvalid_i = (cyc >= w_dly); wdata_i = data; wstrb_i = strb; end
      chk(aw_done ? "awready_held" : "awready_idle", awready_o, !aw_done);
      chk(w_done ? "wready_held" : "wready_idle", wready_o, !w_done);
      chk("bvalid_idle", bvalid_o, 1'b0);
      aw_f = awvalid_i && awready_o;
      w_f  = wvalid_i && wready_o;
      @(posedge clk); #1;
      cyc++;
      if (aw_f) begin aw_done = 1; awvalid_i = 0; end
      if (w_f) begin w_done = 1; wvalid_i = 0; end
    end
    chk("wr_hs_done", {aw_done, w_done}, 2'b11);
    if (w < NR) begin
      for (int b = 0; b < SW; b++) if (strb[b]) m_regs[w][b*8 +: 8] = data[b*8 +: 8];
      exp_p[w] = 1'b1;
    end
    chk("bvalid_commit", bvalid_o, 1'b1);
    chk("bresp", bresp_o, exp_b);
    chk("wr_pulse", wr_pulse_o, exp_p);
    chk("regs_after_commit", regs_o, m_flat());
    b_f = 0;
    for (int k = 0; k < 64 && !b_f; k++) begin
      bready_i = (k >= bdly);
      if (nxt_en) begin awvalid_i = 1; awaddr_i = nxt_addr; end
      chk("bvalid_hold", bvalid_o, 1'b1);
      chk("awready_busy", awready_o, 1'b0);
      chk("wready_busy", wready_o, 1'b0);
      if (k > 0) chk("wr_pulse_single", wr_pulse_o, '0);
      b_f = bready_i && bvalid_o;
      @(posedge clk); #1;
    end
    bready_i = 0;
    chk("b_hs_done", b_f, 1'b1);
    chk("bvalid_clr", bvalid_o, 1'b0);
    chk("awready_back", awready_o, 1'b1);
    chk("wready_back", wready_o, 1'b1);
    chk("regs_stable", regs_o, m_flat());
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int rdly);
    int w;
    bit f;
    logic [DW-1:0] ed;
    logic [1:0] er;
    w = word_of(addr);
    ed = '0; er = 2'b11;
    if (w < NR) begin ed = m_regs[w]; er = 2'b00; end
    else if (w < NR + NS) begin ed = m_stat[w-NR]; er = 2'b00; end
    araddr_i = addr; arvalid_i = 1;
    chk("arready_idle", arready_o, 1'b1);
    @(posedge clk); #1;
    arvalid_i = 0;
    for (int s = 0; s < NS; s++) m_stat[s] = $urandom;
    chk("rvalid_set", rvalid_o, 1'b1);
    chk("rdata", rdata_o, ed);
    chk("rresp", rresp_o, er);
    f = 0;
    for (int k = 0; k < 64 && !f; k++) begin
      rready_i = (k >= rdly);
      chk("rvalid_hold", rvalid_o, 1'b1);
      chk("arready_busy", arready_o, 1'b0);
      chk("rdata_hold", rdata_o, ed);
      f = rready_i && rvalid_o;
      @(posedge clk); #1;
    end
    rready_i = 0;
    chk("r_hs_done", f, 1'b1);
    chk("rvalid_clr", rvalid_o, 1'b0);
    chk("arready_back", arready_o, 1'b1);
    chk("rdata_keep", rdata_o, ed);
  endtask

  task automatic chk_reset_vals();
    chk("rst_awready", awready_o, 1'b1);
    chk("rst_wready", wready_o, 1'b1);
    chk("rst_arready", arready_o, 1'b1);
    chk("rst_bvalid", bvalid_o, 1'b0);
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_bresp", bresp_o, 2'b00);
    chk("rst_rresp", rresp_o, 2'b00);
    chk("rst_rdata", rdata_o, '0);
    chk("rst_regs", regs_o, '0);
    chk("rst_wr_pulse", wr_pulse_o, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    areset = 1;
    awaddr_i = '0; awvalid_i = 0; wdata_i = '0; wstrb_i = '0; wvalid_i = 0;
    bready_i = 0; araddr_i = '0; arvalid_i = 0; rready_i = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    for (int s = 0; s < NS; s++) m_stat[s] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    areset = 0;

    // W leads AW by 3 cycles from reset; only bytes 0 and 2 land.
    do_write(32'h14, 32'h12345678, 4'b0101, 3, 0, 0, 0, '0);
    chk("reg5_partial", regs_o[5*DW +: DW], 32'h00340078);

    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, '0);
    do_read(32'h04, 0);

    // Read of reg 0 races a commit to reg 0 on the same edge: old value returned.
    fork
      do_write(32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, '0);
      do_read(32'h00, 0);
    join
    do_read(32'h00, 1);

    do_write(32'h18, 32'h1, 4'hF, 0, 1, 0, 0, '0);
    do_write(32'h20, 32'h5A5A5A5A, 4'hF, 1, 0, 0, 0, '0);
    do_write(32'h08, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, '0);
    m_stat[1] = 32'hCAFE;
    do_read(32'h1C, 2);
    do_read(32'h100, 0);

    // Held B response with a second AW waiting behind it.
    do_write(32'h0C, 32'hA5A5_0F0F, 4'hF, 0, 0, 5, 1, 32'h08);
    do_write(32'h08, 32'h0BAD_F00D, 4'hF, 0, 2, 0, 0, '0);
    do_read(32'h04, 0);

    // Async reset while only AW is buffered.
    @(posedge clk); #1;
    awvalid_i = 1; awaddr_i = 32'h0C;
    @(posedge clk); #1;
    awvalid_i = 0;
    chk("aw_buffered", awready_o, 1'b0);
    chk("w_not_buffered", wready_o, 1'b1);
    #2 areset = 1;
    #1 chk_reset_vals();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    @(posedge clk); #1;
    areset = 0;
    for (int k = 0; k < 3; k++) begin
      chk("no_b_after_reset", bvalid_o, 1'b0);
      @(posedge clk); #1;
    end
    do_write(32'h0C, 32'h1357_9BDF, 4'hF, 0, 1, 0, 0, '0);
    do_read(32'h0C, 0);

    for (int it = 0; it < 150; it++) begin
      a = ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, SW'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), 0, '0);
      else
        do_read(a, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
